bus_interconnect: RTL and testbench

BUS_INTERCONNECT -- requirements
Module: bus_interconnect

---
 rtl/bus_pkg.sv | 48 ++++
 rtl/bus_if.sv | 39 +++
 rtl/bus_decoder.sv | 30 +++
 rtl/bus_interconnect.sv | 175 +++++++++++++++++
 tb/tb_bus_interconnect.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/bus_pkg.sv
// Shared types and defaults for the peripheral bus interconnect.
// Holds the FSM state encoding and the default eight-slot address map.
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam int DEF_N_SLAVES = 8;
    localparam int DEF_DATA_W   = 32;
    localparam int DEF_ADDR_W   = 32;
    localparam int DEF_TIMEOUT  = 255;

    localparam int SLOT_RAM    = 0;
    localparam int SLOT_SW     = 1;
    localparam int SLOT_UART_A = 2;
    localparam int SLOT_UART_B = 3;
    localparam int SLOT_UART_C = 4;
    localparam int SLOT_LED    = 5;
    localparam int SLOT_SEG    = 6;
    localparam int SLOT_RSVD   = 7;

    // Slot 7 is reserved: a zero mask against a non-zero base never hits.
    localparam logic [DEF_N_SLAVES-1:0][DEF_ADDR_W-1:0] DEF_SLV_BASE = {
        32'hFFFF_FFFF,
        32'h1000_0500,
        32'h1000_0400,
        32'h1000_0300,
        32'h1000_0200,
        32'h1000_0100,
        32'h1000_0000,
        32'h0000_0000
    };

    localparam logic [DEF_N_SLAVES-1:0][DEF_ADDR_W-1:0] DEF_SLV_MASK = {
        32'h0000_0000,
        32'hFFFF_FF00,
        32'hFFFF_FF00,
        32'hFFFF_FF00,
        32'hFFFF_FF00,
        32'hFFFF_FF00,
        32'hFFFF_FF00,
        32'hFFFF_0000
    };

endpackage

// File: rtl/bus_if.sv
// Master-side request/response and slave-side fan-out bundle.
// The interconnect takes the slave modport; the environment the master one.
interface bus_if
    import bus_pkg::*;
#(
    parameter int N_SLAVES = DEF_N_SLAVES,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W
);

    logic                         req_i;
    logic                         we_i;
    logic [ADDR_W-1:0]            addr_i;
    logic [DATA_W-1:0]            wdata_i;
    logic [DATA_W-1:0]            rdata_o;
    logic                         ready_o;
    logic                         err_o;
    logic [N_SLAVES-1:0]          sel_o;
    logic                         we_o;
    logic [ADDR_W-1:0]            addr_o;
    logic [DATA_W-1:0]            wdata_o;
    logic [N_SLAVES*DATA_W-1:0]   rdata_i;
    logic [N_SLAVES-1:0]          ready_i;
    logic [ADDR_W-1:0]            err_addr_o;
    logic [15:0]                  err_cnt_o;

    modport slave (
        input  req_i, we_i, addr_i, wdata_i, rdata_i, ready_i,
        output rdata_o, ready_o, err_o, sel_o, we_o, addr_o,
        output wdata_o, err_addr_o, err_cnt_o
    );

    modport master (
        output req_i, we_i, addr_i, wdata_i, rdata_i, ready_i,
        input  rdata_o, ready_o, err_o, sel_o, we_o, addr_o,
        input  wdata_o, err_addr_o, err_cnt_o
    );

endinterface

// File: rtl/bus_decoder.sv
// Combinational address match against the slot map.
// Overlapping slots resolve to the lowest index.
module bus_decoder
    import bus_pkg::*;
#(
    parameter int N_SLAVES = DEF_N_SLAVES,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter logic [N_SLAVES-1:0][ADDR_W-1:0] SLV_BASE = DEF_SLV_BASE,
    parameter logic [N_SLAVES-1:0][ADDR_W-1:0] SLV_MASK = DEF_SLV_MASK
) (
    input  logic [ADDR_W-1:0]   addr,
    output logic [N_SLAVES-1:0] hit,
    output logic                hit_valid
);

    logic [N_SLAVES-1:0] match;

    // Raw per-slot match, possibly several bits set.
    always_comb begin
        match = '0;
        for (int k = 0; k < N_SLAVES; k++) begin
            match[k] = ((addr & SLV_MASK[k]) == SLV_BASE[k]);
        end
    end

    // Isolate the lowest set bit.
    assign hit       = match & (~match + N_SLAVES'(1));
    assign hit_valid = |match;

endmodule

// File: rtl/bus_interconnect.sv
// Single-master to N-slave interconnect with per-access timeout.
// Errors (unmapped or timed out) are logged in err_addr_o/err_cnt_o.
module bus_interconnect
    import bus_pkg::*;
#(
    parameter int N_SLAVES = DEF_N_SLAVES,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int TIMEOUT  = DEF_TIMEOUT,
    parameter logic [N_SLAVES-1:0][ADDR_W-1:0] SLV_BASE = DEF_SLV_BASE,
    parameter logic [N_SLAVES-1:0][ADDR_W-1:0] SLV_MASK = DEF_SLV_MASK
) (
    input logic  clk_i,
    input logic  rst_i,
    bus_if.slave bus
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_t              state;
    state_t              state_nxt;

    logic [N_SLAVES-1:0] hit;
    logic                hit_valid;

    logic [N_SLAVES-1:0] sel;
    logic                we;
    logic [ADDR_W-1:0]   addr;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W-1:0]   rdata;
    logic                err;
    logic [CNT_W-1:0]    wait_cnt;
    logic [ADDR_W-1:0]   err_addr;
    logic [15:0]         err_cnt;

    logic                slv_ready;
    logic [DATA_W-1:0]   slv_rdata;

    logic                start;
    logic                miss;
    logic                done;
    logic                expire;
    logic                fault;

    bus_decoder #(
        .N_SLAVES (N_SLAVES),
        .ADDR_W   (ADDR_W),
        .SLV_BASE (SLV_BASE),
        .SLV_MASK (SLV_MASK)
    ) u_decoder (
        .addr      (bus.addr_i),
        .hit       (hit),
        .hit_valid (hit_valid)
    );

    // Only the selected slot's ready and read data are observed.
    always_comb begin
        slv_rdata = '0;
        for (int k = 0; k < N_SLAVES; k++) begin
            if (sel[k]) begin
                slv_rdata = slv_rdata | bus.rdata_i[k*DATA_W +: DATA_W];
            end
        end
    end

    assign slv_ready = |(bus.ready_i & sel);

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and per-cycle transaction events.
    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        miss      = 1'b0;
        done      = 1'b0;
        expire    = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.req_i) begin
                    if (hit_valid) begin
                        start     = 1'b1;
                        state_nxt = ACCESS;
                    end else begin
                        miss      = 1'b1;
                        state_nxt = RESP;
                    end
                end
            end
            ACCESS: begin
                if (slv_ready) begin
                    done      = 1'b1;
                    state_nxt = RESP;
                end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                    expire    = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign fault = miss | expire;

    // Latched request, response capture and error log.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sel      <= '0;
            we       <= 1'b0;
            addr     <= '0;
            wdata    <= '0;
            rdata    <= '0;
            err      <= 1'b0;
            wait_cnt <= '0;
            err_addr <= '0;
            err_cnt  <= '0;
        end else begin
            if (start) begin
                sel      <= hit;
                we       <= bus.we_i;
                addr     <= bus.addr_i;
                wdata    <= bus.wdata_i;
                rdata    <= '0;
                err      <= 1'b0;
                wait_cnt <= '0;
            end
            if (state == ACCESS) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end
            if (done) begin
                sel   <= '0;
                we    <= 1'b0;
                rdata <= we ? '0 : slv_rdata;
                err   <= 1'b0;
            end
            if (expire) begin
                sel      <= '0;
                we       <= 1'b0;
                rdata    <= '0;
                err      <= 1'b1;
                err_addr <= addr;
            end
            if (miss) begin
                rdata    <= '0;
                err      <= 1'b1;
                err_addr <= bus.addr_i;
            end
            if (fault && err_cnt != 16'hFFFF) begin
                err_cnt <= err_cnt + 16'd1;
            end
        end
    end

    assign bus.ready_o    = (state == RESP);
    assign bus.err_o      = bus.ready_o & err;
    assign bus.rdata_o    = (bus.ready_o && !err) ? rdata : '0;
    assign bus.sel_o      = sel;
    assign bus.we_o       = we;
    assign bus.addr_o     = addr;
    assign bus.wdata_o    = wdata;
    assign bus.err_addr_o = err_addr;
    assign bus.err_cnt_o  = err_cnt;

endmodule

// File: tb/tb_bus_interconnect.sv
// Directed bench: expected responses go to per-DUT queues,
// negedge monitors pop and compare whenever ready_o is seen.
module tb_bus_interconnect;

    localparam int NS = 8;
    localparam int DW = 32;
    localparam int AW = 32;

    // Slots 2 and 5 both cover 0x2000_0000..; slot 2 must win.
    localparam logic [NS-1:0][AW-1:0] OVL_BASE = {
        32'hFFFF_FFFF, 32'h1000_0500, 32'h2000_0000, 32'h1000_0300,
        32'h1000_0200, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000
    };
    localparam logic [NS-1:0][AW-1:0] OVL_MASK = {
        32'h0000_0000, 32'hFFFF_FF00, 32'hFFFF_0000, 32'hFFFF_FF00,
        32'hFFFF_FF00, 32'hF000_0000, 32'hFFFF_FF00, 32'hFFFF_0000
    };

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   errors;
    int   checks;
    int   c;
    exp_t qa[$];
    exp_t qb[$];

    bus_if #(.N_SLAVES(NS), .DATA_W(DW), .ADDR_W(AW)) ba ();
    bus_if #(.N_SLAVES(NS), .DATA_W(DW), .ADDR_W(AW)) bb ();

    bus_interconnect #(
        .N_SLAVES (NS),
        .DATA_W   (DW),
        .ADDR_W   (AW),
        .TIMEOUT  (255)
    ) dut_a (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (ba)
    );

    bus_interconnect #(
        .N_SLAVES (NS),
        .DATA_W   (DW),
        .ADDR_W   (AW),
        .TIMEOUT  (4),
        .SLV_BASE (OVL_BASE),
        .SLV_MASK (OVL_MASK)
    ) dut_b (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bb)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic issue(input bit on_b, input logic [31:0] a,
                         input logic w, input logic [31:0] d,
                         output int at);
        @(posedge clk);
        #1;
        at = cyc;
        if (on_b) begin
            bb.req_i = 1'b1; bb.addr_i = a; bb.we_i = w; bb.wdata_i = d;
        end else begin
            ba.req_i = 1'b1; ba.addr_i = a; ba.we_i = w; ba.wdata_i = d;
        end
    endtask

    always @(negedge clk) begin : mon_a
        exp_t e;
        if (ba.ready_o === 1'b1) begin
            if (qa.size() == 0) begin
                chk("a_spurious_ready", 32'(ba.ready_o), 32'd0);
            end else begin
                e = qa.pop_front();
                chk("a_rdata", ba.rdata_o, e.rdata);
                chk("a_err", 32'(ba.err_o), 32'(e.err));
                chk("a_ready_cycle", cyc, e.cyc);
            end
        end
    end

    always @(negedge clk) begin : mon_b
        exp_t e;
        if (bb.ready_o === 1'b1) begin
            if (qb.size() == 0) begin
                chk("b_spurious_ready", 32'(bb.ready_o), 32'd0);
            end else begin
                e = qb.pop_front();
                chk("b_rdata", bb.rdata_o, e.rdata);
                chk("b_err", 32'(bb.err_o), 32'(e.err));
                chk("b_ready_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        clk = 1'b0; rst = 1'b1; cyc = 0; errors = 0; checks = 0;
        ba.req_i = 0; ba.we_i = 0; ba.addr_i = '0; ba.wdata_i = '0;
        ba.rdata_i = '0; ba.ready_i = '0;
        bb.req_i = 0; bb.we_i = 0; bb.addr_i = '0; bb.wdata_i = '0;
        bb.rdata_i = '0; bb.ready_i = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(ba.ready_o), 32'd0);
        chk("rst_sel", 32'(ba.sel_o), 32'd0);
        chk("rst_addr_o", ba.addr_o, 32'd0);
        chk("rst_wdata_o", ba.wdata_o, 32'd0);
        chk("rst_we_o", 32'(ba.we_o), 32'd0);
        chk("rst_err_cnt", 32'(ba.err_cnt_o), 32'd0);
        chk("rst_err_addr", ba.err_addr_o, 32'd0);
        chk("rst_b_sel", 32'(bb.sel_o), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // RAM read, slave always ready: minimum latency
        ba.rdata_i[0*DW +: DW] = 32'hDEAD_BEEF;
        ba.ready_i[0] = 1'b1;
        issue(0, 32'h0000_0010, 1'b0, 32'h0, c);
        qa.push_back('{32'hDEAD_BEEF, 1'b0, c + 2});
        @(posedge clk);
        #1 ba.req_i = 1'b0;
        @(negedge clk);
        chk("t1_sel", 32'(ba.sel_o), 32'h01);
        repeat (3) @(posedge clk);
        #1 ba.ready_i[0] = 1'b0;

        // LED write, ready after 5 wait cycles, stray req while busy
        ba.rdata_i[5*DW +: DW] = 32'h1234_5678;
        issue(0, 32'h1000_0400, 1'b1, 32'h0000_00FF, c);
        qa.push_back('{32'h0, 1'b0, c + 7});
        @(posedge clk);
        #1 ba.req_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("t2_sel", 32'(ba.sel_o), 32'h20);
            chk("t2_addr_o", ba.addr_o, 32'h1000_0400);
            chk("t2_wdata_o", ba.wdata_o, 32'h0000_00FF);
            chk("t2_we_o", 32'(ba.we_o), 32'd1);
            if (i == 1) begin
                ba.req_i = 1'b1; ba.addr_i = 32'hFFFF_0000; ba.we_i = 1'b0;
            end
            if (i == 3) ba.req_i = 1'b0;
        end
        ba.ready_i[5] = 1'b1;
        @(posedge clk);
        #1 ba.ready_i[5] = 1'b0;
        @(negedge clk);
        chk("t2_sel_clr", 32'(ba.sel_o), 32'd0);
        chk("t2_we_clr", 32'(ba.we_o), 32'd0);
        chk("t2_no_err", 32'(ba.err_cnt_o), 32'd0);
        repeat (2) @(posedge clk);

        // Unmapped address
        issue(0, 32'hFFFF_0000, 1'b0, 32'h0, c);
        qa.push_back('{32'h0, 1'b1, c + 1});
        @(posedge clk);
        #1 ba.req_i = 1'b0;
        @(negedge clk);
        chk("t3_sel_resp", 32'(ba.sel_o), 32'd0);
        @(negedge clk);
        chk("t3_sel_idle", 32'(ba.sel_o), 32'd0);
        chk("t3_err_addr", ba.err_addr_o, 32'hFFFF_0000);
        chk("t3_err_cnt", 32'(ba.err_cnt_o), 32'd1);

        // Reset in the middle of an access
        issue(0, 32'h1000_0000, 1'b0, 32'h0, c);
        @(posedge clk);
        #1 ba.req_i = 1'b0;
        @(negedge clk);
        chk("t4_sel_pre", 32'(ba.sel_o), 32'h02);
        rst = 1'b1;
        @(negedge clk);
        chk("t4_sel", 32'(ba.sel_o), 32'd0);
        chk("t4_ready", 32'(ba.ready_o), 32'd0);
        chk("t4_addr_o", ba.addr_o, 32'd0);
        chk("t4_err_cnt", 32'(ba.err_cnt_o), 32'd0);
        chk("t4_err_addr", ba.err_addr_o, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        ba.rdata_i[1*DW +: DW] = 32'h0000_00A5;
        ba.ready_i[1] = 1'b1;
        issue(0, 32'h1000_0000, 1'b0, 32'h0, c);
        qa.push_back('{32'h0000_00A5, 1'b0, c + 2});
        @(posedge clk);
        #1 ba.req_i = 1'b0;
        repeat (3) @(posedge clk);
        #1 ba.ready_i[1] = 1'b0;

        // TIMEOUT=4, slave never answers
        bb.rdata_i[0*DW +: DW] = 32'h1111_1111;
        issue(1, 32'h0000_0020, 1'b0, 32'h0, c);
        qb.push_back('{32'h0, 1'b1, c + 5});
        @(posedge clk);
        #1 bb.req_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t5_sel", 32'(bb.sel_o), 32'h01);
        end
        @(negedge clk);
        chk("t5_sel_drop", 32'(bb.sel_o), 32'd0);
        @(negedge clk);
        chk("t5_err_cnt", 32'(bb.err_cnt_o), 32'd1);
        chk("t5_err_addr", bb.err_addr_o, 32'h0000_0020);

        // Overlapping slots: lowest wins, other ready ignored
        bb.rdata_i[2*DW +: DW] = 32'hCAFE_0002;
        bb.rdata_i[5*DW +: DW] = 32'h5555_5555;
        issue(1, 32'h2000_0004, 1'b0, 32'h0, c);
        qb.push_back('{32'hCAFE_0002, 1'b0, c + 3});
        @(posedge clk);
        #1 bb.req_i = 1'b0;
        @(negedge clk);
        chk("t6_sel", 32'(bb.sel_o), 32'h04);
        bb.ready_i[5] = 1'b1;
        @(posedge clk);
        #1 bb.ready_i[5] = 1'b0;
        @(negedge clk);
        chk("t6_sel_hold", 32'(bb.sel_o), 32'h04);
        bb.ready_i[2] = 1'b1;
        @(posedge clk);
        #1 bb.ready_i[2] = 1'b0;

        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("a_queue_drained", 32'(qa.size()), 32'd0);
        chk("b_queue_drained", 32'(qb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
